// File: rtl/atm_card_session_ctrl_pkg.sv
// Shared types and sizes for the ATM card/session controller.
// Widths, the wrong-PIN limit, FSM states and the account entry layout.
package atm_card_session_ctrl_pkg;

   localparam int P_WIDTH    = 16;
   localparam int B_WIDTH    = 20;
   localparam int C_WIDTH    = 4;
   localparam int MAX_WRONG  = 3;
   localparam int N_ACCOUNTS = 1 << C_WIDTH;
   localparam int CNT_W      = $clog2(MAX_WRONG + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_GRANT,
      S_SESSION,
      S_WRITEBACK,
      S_EJECT,
      S_REJECT
   } state_t;

   // Source selected onto the table's single write port
   typedef enum logic [1:0] {
      WR_NONE,
      WR_CFG,
      WR_BAL,
      WR_LOCK
   } wr_sel_t;

   typedef struct packed {
      logic               lock;
      logic [P_WIDTH-1:0] pw;
      logic [B_WIDTH-1:0] bal;
   } acct_t;

endpackage

// File: rtl/atm_card_session_ctrl_account_table.sv
// Account register file: one sync write port (cfg / balance / lock-set)
// and one registered read port. Ports: clk, rst, wr_sel, cfg_*, sess_addr,
// wb_balance, rd_addr, rd_data.
module atm_account_table
   import atm_card_session_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  wr_sel_t            wr_sel,
   input  logic [C_WIDTH-1:0] cfg_addr,
   input  acct_t              cfg_entry,
   input  logic [C_WIDTH-1:0] sess_addr,
   input  logic [B_WIDTH-1:0] wb_balance,
   input  logic [C_WIDTH-1:0] rd_addr,
   output acct_t              rd_data
);

   acct_t              mem [N_ACCOUNTS];
   logic               wr_en;
   logic [C_WIDTH-1:0] wr_addr;
   acct_t              wr_data;

   // Session writes modify only one field of the current entry
   always_comb begin
      wr_en   = 1'b1;
      wr_addr = sess_addr;
      wr_data = mem[sess_addr];
      unique case (wr_sel)
         WR_CFG: begin
            wr_addr = cfg_addr;
            wr_data = cfg_entry;
         end
         WR_BAL:  wr_data.bal  = wb_balance;
         WR_LOCK: wr_data.lock = 1'b1;
         WR_NONE: wr_en = 1'b0;
         default: wr_en = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_ACCOUNTS; i++) begin
            mem[i] <= '0;
         end
         rd_data <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_addr] <= wr_data;
         end
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/atm_card_session_ctrl.sv
// Card/session controller: looks up the inserted card, loads the ATM FSM,
// counts wrong PINs, writes back balance / lock, and ejects the card.
// Ports: card reader, admin cfg_*, FSM handshake, status outputs.
module atm_card_session_ctrl
   import atm_card_session_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               card_inserted,
   input  logic [C_WIDTH-1:0] card_num,
   input  logic               cfg_we,
   input  logic [C_WIDTH-1:0] cfg_addr,
   input  logic [P_WIDTH-1:0] cfg_password,
   input  logic [B_WIDTH-1:0] cfg_balance,
   input  logic               wrong_password,
   input  logic               card_out,
   input  logic [B_WIDTH-1:0] updated_balance,
   output logic               pass_en,
   output logic [P_WIDTH-1:0] user_password,
   output logic [B_WIDTH-1:0] current_balance,
   output logic               card_eject,
   output logic               card_rejected,
   output logic               acct_locked,
   output logic               session_active,
   output logic               cfg_busy
);

   state_t             state;
   state_t             state_nxt;
   wr_sel_t            wr_sel;
   acct_t              rd_data;
   acct_t              cfg_entry;
   logic [C_WIDTH-1:0] card_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               wp_q;
   logic               rej_q;
   logic               take_card;
   logic               load;
   logic               clr;
   logic               wp_rise;

   assign cfg_entry = '{lock: 1'b0, pw: cfg_password, bal: cfg_balance};
   assign take_card = (state == S_IDLE) && card_inserted && !cfg_we;
   assign wp_rise   = wrong_password && !wp_q;

   // The table read always follows card_num, so the entry sampled on
   // the IDLE->LOOKUP edge is the one for the latched card.
   atm_account_table u_table (
      .clk        (clk),
      .rst        (rst),
      .wr_sel     (wr_sel),
      .cfg_addr   (cfg_addr),
      .cfg_entry  (cfg_entry),
      .sess_addr  (card_q),
      .wb_balance (updated_balance),
      .rd_addr    (card_num),
      .rd_data    (rd_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      wr_sel      = WR_NONE;
      pass_en     = 1'b0;
      acct_locked = 1'b0;
      load        = 1'b0;
      clr         = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (cfg_we) begin
               wr_sel = WR_CFG;
            end else if (card_inserted) begin
               state_nxt = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (rd_data.lock) begin
               state_nxt = S_REJECT;
            end else begin
               load      = 1'b1;
               state_nxt = S_GRANT;
            end
         end
         S_GRANT: begin
            pass_en   = 1'b1;
            state_nxt = S_SESSION;
         end
         S_SESSION: begin
            if (cnt_q == CNT_W'(MAX_WRONG)) begin
               wr_sel      = WR_LOCK;
               acct_locked = 1'b1;
               state_nxt   = S_EJECT;
            end else if (card_out || !card_inserted) begin
               state_nxt = S_WRITEBACK;
            end
         end
         S_WRITEBACK: begin
            wr_sel    = WR_BAL;
            state_nxt = S_EJECT;
         end
         S_EJECT, S_REJECT: begin
            if (!card_inserted) begin
               clr       = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         card_q          <= '0;
         user_password   <= '0;
         current_balance <= '0;
         cnt_q           <= '0;
         wp_q            <= 1'b0;
         rej_q           <= 1'b0;
      end else begin
         wp_q  <= wrong_password;
         rej_q <= (state == S_LOOKUP) && rd_data.lock;
         if (take_card) begin
            card_q <= card_num;
         end
         if (load) begin
            user_password   <= rd_data.pw;
            current_balance <= rd_data.bal;
         end else if (clr) begin
            user_password   <= '0;
            current_balance <= '0;
         end
         if (clr) begin
            cnt_q <= '0;
         end else if ((state == S_SESSION) && wp_rise &&
                      (cnt_q < CNT_W'(MAX_WRONG))) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign card_eject     = (state == S_EJECT) || (state == S_REJECT);
   assign card_rejected  = rej_q;
   assign session_active = (state == S_GRANT) || (state == S_SESSION);
   assign cfg_busy       = (state != S_IDLE);

endmodule
